// File: rtl/weight_pkg.sv
// Shared constants, FSM states and LFSR-to-weight mapping for weight_ram_ctrl.
// Define WINIT_CLAMP_EN to narrow initial weights to -64..63 (default -512..511).
package weight_pkg;

   localparam int NUM_WEIGHTS = 165;
   localparam int AW          = 8;
   localparam int DW          = 10;
   localparam int LFSR_W      = 16;

   // Right-shifting Fibonacci form: bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1.
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [AW-1:0]     LAST_ADDR    = AW'(NUM_WEIGHTS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      INIT  = 2'd1,
      READY = 2'd2
   } state_t;

   function automatic logic [DW-1:0] lfsr_to_weight(input logic [DW-1:0] bits);
`ifdef WINIT_CLAMP_EN
      return $signed(bits) >>> 3;
`else
      return bits;
`endif
   endfunction

   function automatic logic in_range(input logic [AW-1:0] addr);
      return addr < AW'(NUM_WEIGHTS);
   endfunction

endpackage

// File: rtl/weight_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load; a zero seed is replaced by DEFAULT_SEED.
module weight_lfsr
   import weight_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              en,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == '0) ? DEFAULT_SEED : seed;
      end else if (en) begin
         state_d = {^(state_q & LFSR_TAPS), state_q[LFSR_W-1:1]};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= DEFAULT_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/weight_ram_ctrl.sv
// Weight RAM sequencer: LFSR fill on Start, then round-robin share of the single
// RAM port between forward reads and training writes. Honours WINIT_CLAMP_EN.
module weight_ram_ctrl
   import weight_pkg::*;
(
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Start,
   input  logic [LFSR_W-1:0] Seed,
   output logic              Busy,
   output logic              Done,
   input  logic              FwdReq,
   input  logic [AW-1:0]     FwdAddr,
   output logic              FwdGnt,
   output logic [DW-1:0]     RdData,
   output logic              RdValid,
   input  logic              UpdReq,
   input  logic [AW-1:0]     UpdAddr,
   input  logic [DW-1:0]     UpdData,
   output logic              UpdGnt,
   output logic              AddrErr,
   output logic [DW-1:0]     RamD,
   output logic [AW-1:0]     RamAddress,
   output logic              RamWE,
   input  logic [DW-1:0]     RamQ
);

   state_t            state_q, state_d;
   logic [AW-1:0]     count_q, count_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_valid_q, rd_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              upd_prio_q, upd_prio_d;

   logic [LFSR_W-1:0] lfsr_state;
   logic              lfsr_load;
   logic              lfsr_en;
   logic              lfsr_unused;
   logic              ready;
   logic              fwd_gnt;
   logic              upd_gnt;

   weight_lfsr u_lfsr (
      .clk   (Clock),
      .rst_n (Rst),
      .load  (lfsr_load),
      .seed  (Seed),
      .en    (lfsr_en),
      .state (lfsr_state)
   );

   // Only the low DW bits become a weight; the rest just feed the shift register.
   assign lfsr_unused = ^lfsr_state[LFSR_W-1:DW];

   // Grants and RAM pins are gated by Rst so a reset cycle never touches the RAM.
   always_comb begin
      ready   = Rst && (state_q == READY);
      upd_gnt = ready && UpdReq && (!FwdReq || upd_prio_q);
      fwd_gnt = ready && FwdReq && !upd_gnt;
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      upd_prio_d = upd_prio_q;
      lfsr_load  = 1'b0;
      lfsr_en    = 1'b0;
      case (state_q)
         IDLE, READY: begin
            if (Start) begin
               state_d   = INIT;
               count_d   = '0;
               lfsr_load = 1'b1;
            end
         end
         INIT: begin
            lfsr_en = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == LAST_ADDR) begin
               state_d = READY;
            end
         end
         default: state_d = IDLE;
      endcase

      // The loser of a conflict wins the next one.
      if (ready && FwdReq && UpdReq) begin
         upd_prio_d = !upd_gnt;
      end

      busy_d     = (state_d == INIT);
      done_d     = (state_d == INIT) && (count_d == LAST_ADDR);
      rd_valid_d = fwd_gnt;
      addr_err_d = (fwd_gnt && !in_range(FwdAddr)) || (upd_gnt && !in_range(UpdAddr));
   end

   always_comb begin
      RamWE      = 1'b0;
      RamAddress = '0;
      RamD       = '0;
      if (Rst && (state_q == INIT)) begin
         RamWE      = 1'b1;
         RamAddress = count_q;
         RamD       = lfsr_to_weight(lfsr_state[DW-1:0]);
      end else if (upd_gnt) begin
         RamWE      = in_range(UpdAddr);
         RamAddress = UpdAddr;
         RamD       = UpdData;
      end else if (fwd_gnt) begin
         RamAddress = FwdAddr;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         upd_prio_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_valid_q <= rd_valid_d;
         addr_err_q <= addr_err_d;
         upd_prio_q <= upd_prio_d;
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign RdValid = rd_valid_q;
   assign AddrErr = addr_err_q;
   assign FwdGnt  = fwd_gnt;
   assign UpdGnt  = upd_gnt;
   assign RdData  = RamQ;

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Self-checking bench for weight_ram_ctrl: a behavioural RAM plus a reference
// model of LFSR fill, round-robin arbitration and address-error pulses.
module tb_weight_ram_ctrl;

   localparam int N = 165;
`ifdef WINIT_CLAMP_EN
   localparam logic [9:0] EXP0_SEED1 = 10'h000;
   localparam logic [9:0] EXP0_SEED0 = 10'h01C;
`else
   localparam logic [9:0] EXP0_SEED1 = 10'h001;
   localparam logic [9:0] EXP0_SEED0 = 10'h0E1;
`endif

   logic        Clock = 1'b0;
   logic        Rst = 1'b0;
   logic        Start = 1'b0;
   logic [15:0] Seed = '0;
   logic        Busy, Done;
   logic        FwdReq = 1'b0;
   logic [7:0]  FwdAddr = '0;
   logic        FwdGnt;
   logic [9:0]  RdData;
   logic        RdValid;
   logic        UpdReq = 1'b0;
   logic [7:0]  UpdAddr = '0;
   logic [9:0]  UpdData = '0;
   logic        UpdGnt, AddrErr;
   logic [9:0]  RamD;
   logic [7:0]  RamAddress;
   logic        RamWE;
   logic [9:0]  RamQ;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [9:0]  exp_mem [0:N-1];
   logic        upd_turn = 1'b1;
   logic [9:0]  ram [0:255];

   weight_ram_ctrl dut (
      .Clock(Clock), .Rst(Rst), .Start(Start), .Seed(Seed), .Busy(Busy), .Done(Done),
      .FwdReq(FwdReq), .FwdAddr(FwdAddr), .FwdGnt(FwdGnt), .RdData(RdData), .RdValid(RdValid),
      .UpdReq(UpdReq), .UpdAddr(UpdAddr), .UpdData(UpdData), .UpdGnt(UpdGnt), .AddrErr(AddrErr),
      .RamD(RamD), .RamAddress(RamAddress), .RamWE(RamWE), .RamQ(RamQ)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) begin
      if (RamWE) ram[RamAddress] <= RamD;
      RamQ <= ram[RamAddress];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_shift(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   function automatic logic [9:0] ref_weight(input logic [15:0] s);
      int v;
      v = int'(s[9:0]);
      if (v > 511) v = v - 1024;
`ifdef WINIT_CLAMP_EN
      v = (v >= 0) ? v / 8 : -((-v + 7) / 8);
`endif
      return v[9:0];
   endfunction

   function automatic logic [7:0] rand_addr();
      if ($urandom_range(9, 0) == 0) return 8'(N + $urandom_range(90, 0));
      return 8'($urandom_range(N - 1, 0));
   endfunction

   task automatic test_reset();
      Rst = 1'b0;
      repeat (2) @(negedge Clock);
      FwdReq = 1'b1; FwdAddr = 8'd4; UpdReq = 1'b1; UpdAddr = 8'd3;
      #1;
      n_checks++;
      if ({Busy, Done, FwdGnt, UpdGnt, RdValid, AddrErr, RamWE} !== 7'b0 || RamAddress !== 8'd0 || RamD !== 10'd0) begin
         n_errors++;
         $display("FAIL reset_values: got busy=%b done=%b fg=%b ug=%b rv=%b ae=%b we=%b addr=%0d d=%h, want all zero",
                  Busy, Done, FwdGnt, UpdGnt, RdValid, AddrErr, RamWE, RamAddress, RamD);
      end
      @(negedge Clock);
      Rst = 1'b1;
      #1;
      n_checks++;
      if (FwdGnt !== 1'b0 || UpdGnt !== 1'b0 || RamWE !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_no_grant: got fg=%b ug=%b we=%b, want 0 0 0", FwdGnt, UpdGnt, RamWE);
      end
      @(negedge Clock);
      FwdReq = 1'b0; UpdReq = 1'b0;
      upd_turn = 1'b1;
   endtask

   task automatic test_init(input logic [15:0] seed, input logic [9:0] exp0);
      logic [15:0] s;
      int writes [N];
      int busy_cnt = 0;
      int done_cnt = 0;
      int bad_cnt = 0;
      foreach (writes[i]) writes[i] = 0;
      @(negedge Clock);
      Seed = seed; Start = 1'b1;
      #1;
      n_checks++;
      if (Busy !== 1'b0) begin
         n_errors++;
         $display("FAIL init_busy_before: got %b want 0", Busy);
      end
      s = (seed == 16'h0) ? 16'hACE1 : seed;
      for (int c = 0; c <= N; c++) begin
         @(negedge Clock);
         Start = 1'b0; Seed = 16'($urandom);
         #1;
         if (Busy === 1'b1) busy_cnt++;
         if (Done === 1'b1) done_cnt++;
         if (RamWE === 1'b1 && RamAddress < N) writes[RamAddress]++;
         n_checks++;
         if (c < N) begin
            if (Busy !== 1'b1 || RamWE !== 1'b1 || RamAddress !== 8'(c) || RamD !== ref_weight(s) || Done !== (c == N - 1)) begin
               n_errors++;
               $display("FAIL init_write[%0d]: got busy=%b we=%b addr=%0d d=%h done=%b, want 1 1 %0d %h %b",
                        c, Busy, RamWE, RamAddress, RamD, Done, c, ref_weight(s), (c == N - 1));
            end
            if (c == 0) begin
               n_checks++;
               if (RamD !== exp0) begin
                  n_errors++;
                  $display("FAIL init_addr0: got %h want %h", RamD, exp0);
               end
            end
            exp_mem[c] = ref_weight(s);
            s = ref_shift(s);
         end else if (Busy !== 1'b0 || Done !== 1'b0 || RamWE !== 1'b0) begin
            n_errors++;
            $display("FAIL init_end: got busy=%b done=%b we=%b, want 0 0 0", Busy, Done, RamWE);
         end
      end
      foreach (writes[i]) if (writes[i] != 1) bad_cnt++;
      n_checks++;
      if (busy_cnt != N || done_cnt != 1 || bad_cnt != 0) begin
         n_errors++;
         $display("FAIL init_counts: got busy_cycles=%0d done_pulses=%0d addrs_not_once=%0d, want %0d 1 0",
                  busy_cnt, done_cnt, bad_cnt, N);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         FwdReq = 1'b1; FwdAddr = 8'd20; UpdReq = 1'b1; UpdAddr = 8'd10; UpdData = 10'($urandom);
         #1;
         n_checks++;
         if (UpdGnt !== (i % 2 == 0) || FwdGnt !== (i % 2 == 1)) begin
            n_errors++;
            $display("FAIL rr_cycle%0d: got ug=%b fg=%b, want ug=%b fg=%b", i, UpdGnt, FwdGnt, (i % 2 == 0), (i % 2 == 1));
         end
         if (i % 2 == 0) exp_mem[10] = UpdData;
         upd_turn = !upd_turn;
      end
      @(negedge Clock);
      FwdReq = 1'b0; UpdReq = 1'b0;
   endtask

   task automatic test_read(input logic [7:0] addr);
      @(negedge Clock);
      FwdReq = 1'b1; FwdAddr = addr;
      #1;
      n_checks++;
      if (FwdGnt !== 1'b1 || UpdGnt !== 1'b0 || RamWE !== 1'b0 || RamAddress !== addr) begin
         n_errors++;
         $display("FAIL read_grant@%0d: got fg=%b ug=%b we=%b addr=%0d, want 1 0 0 %0d", addr, FwdGnt, UpdGnt, RamWE, RamAddress, addr);
      end
      @(negedge Clock);
      FwdReq = 1'b0;
      #1;
      n_checks++;
      if (RdValid !== 1'b1 || AddrErr !== (addr >= N) || (addr < N && RdData !== exp_mem[addr])) begin
         n_errors++;
         $display("FAIL read_data@%0d: got rv=%b ae=%b data=%h, want 1 %b %h", addr, RdValid, AddrErr, RdData,
                  (addr >= N), (addr < N) ? exp_mem[addr] : 10'h0);
      end
      @(negedge Clock);
      #1;
      n_checks++;
      if (RdValid !== 1'b0 || AddrErr !== 1'b0) begin
         n_errors++;
         $display("FAIL read_after@%0d: got rv=%b ae=%b, want 0 0", addr, RdValid, AddrErr);
      end
   endtask

   task automatic test_addr_err();
      @(negedge Clock);
      UpdReq = 1'b1; UpdAddr = 8'd200; UpdData = 10'h155;
      #1;
      n_checks++;
      if (UpdGnt !== 1'b1 || RamWE !== 1'b0 || AddrErr !== 1'b0) begin
         n_errors++;
         $display("FAIL upd_oob_grant: got ug=%b we=%b ae=%b, want 1 0 0", UpdGnt, RamWE, AddrErr);
      end
      @(negedge Clock);
      UpdReq = 1'b0;
      #1;
      n_checks++;
      if (AddrErr !== 1'b1) begin
         n_errors++;
         $display("FAIL upd_oob_err: got %b want 1", AddrErr);
      end
      test_read(8'd164);
      test_read(8'd170);
   endtask

   task automatic test_reset_mid_init();
      int bad = 0;
      @(negedge Clock);
      Seed = 16'($urandom); Start = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge Clock);
         Start = 1'b0;
      end
      #1;
      n_checks++;
      if (Busy !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_init_busy: got %b want 1", Busy);
      end
      @(negedge Clock);
      Rst = 1'b0;
      @(negedge Clock);
      Rst = 1'b1; FwdReq = 1'b1; FwdAddr = 8'd5;
      #1;
      n_checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || FwdGnt !== 1'b0 || RamWE !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_init_reset: got busy=%b done=%b fg=%b we=%b, want 0 0 0 0", Busy, Done, FwdGnt, RamWE);
      end
      for (int c = 0; c < 200; c++) begin
         @(negedge Clock);
         #1;
         if (FwdGnt !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL idle_after_reset: got %0d bad cycles want 0", bad);
      end
      @(negedge Clock);
      FwdReq = 1'b0;
      upd_turn = 1'b1;
   endtask

   task automatic test_random(input int n);
      logic       f_pend = 1'b0, u_pend = 1'b0;
      logic [7:0] fa = '0, ua = '0;
      logic [9:0] ud = '0;
      logic       prev_rd = 1'b0, prev_err = 1'b0;
      logic [7:0] prev_ra = '0;
      logic       exp_u, exp_f, exp_we;
      logic [7:0] exp_a;
      logic [9:0] exp_d;
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         if (!f_pend && $urandom_range(1, 0) == 1) begin f_pend = 1'b1; fa = rand_addr(); end
         if (!u_pend && $urandom_range(1, 0) == 1) begin u_pend = 1'b1; ua = rand_addr(); ud = 10'($urandom); end
         FwdReq = f_pend; FwdAddr = fa; UpdReq = u_pend; UpdAddr = ua; UpdData = ud;
         #1;
         exp_u = u_pend && (!f_pend || upd_turn);
         exp_f = f_pend && !exp_u;
         if (f_pend && u_pend) upd_turn = !exp_u;
         exp_we = exp_u && (ua < N);
         exp_a  = exp_u ? ua : (exp_f ? fa : 8'd0);
         exp_d  = exp_u ? ud : 10'd0;
         n_checks++;
         if (UpdGnt !== exp_u || FwdGnt !== exp_f || RamWE !== exp_we || RamAddress !== exp_a || RamD !== exp_d) begin
            n_errors++;
            $display("FAIL rand_bus[%0d]: got ug=%b fg=%b we=%b a=%0d d=%h, want %b %b %b %0d %h",
                     i, UpdGnt, FwdGnt, RamWE, RamAddress, RamD, exp_u, exp_f, exp_we, exp_a, exp_d);
         end
         n_checks++;
         if (RdValid !== prev_rd || AddrErr !== prev_err || (prev_rd && prev_ra < N && RdData !== exp_mem[prev_ra])) begin
            n_errors++;
            $display("FAIL rand_resp[%0d]: got rv=%b ae=%b data=%h, want rv=%b ae=%b data=%h",
                     i, RdValid, AddrErr, RdData, prev_rd, prev_err, (prev_ra < N) ? exp_mem[prev_ra] : 10'h0);
         end
         if (exp_we) exp_mem[ua] = ud;
         prev_rd  = exp_f;
         prev_ra  = fa;
         prev_err = (exp_f && fa >= N) || (exp_u && ua >= N);
         if (exp_f) f_pend = 1'b0;
         if (exp_u) u_pend = 1'b0;
      end
      @(negedge Clock);
      FwdReq = 1'b0; UpdReq = 1'b0;
      @(negedge Clock);
   endtask

   initial begin
      test_reset();
      test_init(16'h0001, EXP0_SEED1);
      test_back_to_back();
      test_read(8'd7);
      test_addr_err();
      test_reset_mid_init();
      test_init(16'h0000, EXP0_SEED0);
      test_random(400);
      test_read(8'd0);
      test_read(8'd164);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/weight_ram_ctrl.md
# weight_ram_ctrl

Sequencer and arbiter for the 165-entry signed 10-bit weight RAM of the drowsiness-detector network (150 input→hidden weights, 15 hidden→output weights). On a start pulse it fills every RAM entry with pseudo-random signed weights from an LFSR. It then shares the RAM's single port between the forward-pass reader and the training-update writer. It sits between the network datapath and the weight RAM, and is the only block that drives the RAM's D/Address/WE pins.

## Interface
- NUM_WEIGHTS, 165, number of RAM entries initialised/addressable
- AW, 8, address width
- DW, 10, weight width (signed)
- Clock  in  1  rising-edge clock
- Rst  in  1  synchronous, active-low reset
- Start  in  1  one-cycle pulse: begin random initialisation
- Seed  in  16  LFSR seed, sampled on accepted Start
- Busy  out  1  high while initialising
- Done  out  1  one-cycle pulse when the last weight is written
- FwdReq  in  1  forward-pass read request (held until granted)
- FwdAddr  in  AW  read address
- FwdGnt  out  1  read granted this cycle
- RdData  out  DW  read weight (passthrough of RamQ)
- RdValid  out  1  RdData valid
- UpdReq  in  1  training write request (held until granted)
- UpdAddr  in  AW  write address
- UpdData  in  DW  signed weight to write
- UpdGnt  out  1  write granted this cycle
- AddrErr  out  1  one-cycle pulse: granted address ≥ NUM_WEIGHTS
- RamD  out  DW  to RAM D
- RamAddress  out  AW  to RAM Address
- RamWE  out  1  to RAM WE (1 write, 0 read)
- RamQ  in  DW  from RAM Q (registered in RAM, 1-cycle read latency)

## Operation
- FSM: IDLE → INIT → READY. Reset enters IDLE.
- IDLE and INIT grant no requests. Requesters hold Req and address/data stable until Gnt.
- Start in IDLE or READY → INIT. The LFSR loads Seed; Seed==0 is replaced by 16'hACE1. Addr counter is cleared. Start during INIT is ignored.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts once per INIT cycle.
- INIT, each cycle: RamWE=1, RamAddress=count, RamD=weight(LFSR state). Then the LFSR shifts and count increments.
- Address k therefore receives weight(state after k shifts). Address 0 receives weight(Seed).
- On the cycle writing count==NUM_WEIGHTS-1: Done=1 and the next state is READY. Busy=1 for exactly NUM_WEIGHTS cycles.
- READY, with only one requester active: that requester is granted every cycle.
- READY, with both requesters active: round-robin. The requester not granted on the last conflict wins. After reset the Upd requester wins the first conflict.
- Fwd grant: RamWE=0, RamAddress=FwdAddr. RdValid=1 in the following cycle. RdData=RamQ.
- Upd grant: RamWE=1, RamAddress=UpdAddr, RamD=UpdData.
- Upd grant with UpdAddr≥NUM_WEIGHTS: RamWE is forced 0 and AddrErr pulses.
- Fwd grant with FwdAddr≥NUM_WEIGHTS: the read is still performed, RdValid still asserts, RdData is undefined, and AddrErr pulses.
- No grant (any state other than INIT writes): RamWE=0, RamAddress=0, RamD=0.
- Reset mid-INIT: return to IDLE. No Done pulse. RAM contents are partial. Round-robin pointer resets.

## Timing
- Reset values: Busy=0, Done=0, FwdGnt=0, UpdGnt=0, RdValid=0, AddrErr=0, RamWE=0, RamAddress=0, RamD=0.
- RAM drive signals and grants are combinational from state, count, LFSR and requests. The RAM samples them on the next rising edge.
- Start accepted at edge E → first RAM write in cycle E+1 → Done in cycle E+NUM_WEIGHTS → READY from cycle E+NUM_WEIGHTS+1.
- Read latency: FwdGnt in cycle N → RdValid/RdData in cycle N+1.
- Busy, Done, RdValid and AddrErr are registered.

## Configuration
- WINIT_CLAMP_EN defined: weight = LFSR[9:0] interpreted as signed, then arithmetic-shifted right by 3, giving range −64..63.
- WINIT_CLAMP_EN undefined: weight = LFSR[9:0] as signed, giving range −512..511.

## Structure
- Package weight_pkg: NUM_WEIGHTS, AW, DW, the state enum (IDLE/INIT/READY), LFSR tap mask, and DEFAULT_SEED=16'hACE1.
- Sub-module weight_lfsr: load/enable inputs and a 16-bit state output. The controller applies the clamp.

## Test plan
- Reset, then Start with Seed=16'h0001 → Busy high for 165 cycles. Done pulses once in the final write cycle. Address 0 is written 10'h001 (clamp off) or 10'h000 (clamp on). Addresses 0..164 are each written exactly once.
- Start with Seed=0 → address 0 is written 16'hACE1[9:0]=10'h0E1 (clamp off).
- READY, FwdReq=1 with FwdAddr=7 → FwdGnt same cycle, RamWE=0, RamAddress=7. Next cycle RdValid=1 and RdData equals the weight written at address 7.
- READY, FwdReq and UpdReq held together for 4 cycles → grants alternate Upd, Fwd, Upd, Fwd. Never both granted in the same cycle.
- UpdReq with UpdAddr=200 → UpdGnt=1, RamWE=0, AddrErr pulses. A following read of address 164 returns its initialised value unchanged.
- Rst low at INIT cycle 50 → next cycle IDLE, Busy=0, no Done. FwdReq is not granted until a new Start completes.
